// File: rtl/sram_master_pkg.sv
// Shared parameters, types and command legality check for the SRAM burst master.
// Sizes: 22-bit word address (2^21 words usable), 2 words x 3 bytes = 48-bit
// access, 8-bit burst length, 2-entry read response buffer.
package sram_master_pkg;

  localparam int unsigned ADDR_SIZE_BITS  = 22;
  localparam int unsigned DATA_SIZE_WORDS = 2;
  localparam int unsigned WORD_SIZE_BYTES = 3;
  localparam int unsigned ACC_BITS        = DATA_SIZE_WORDS * WORD_SIZE_BYTES * 8;
  localparam int unsigned LEN_BITS        = 8;
  localparam int unsigned RD_FIFO_DEPTH   = 2;
  // Width wide enough that the burst end address can never wrap.
  localparam int unsigned CHK_BITS        = ADDR_SIZE_BITS + LEN_BITS + 1;

  typedef logic [ADDR_SIZE_BITS-1:0] addr_t;
  typedef logic [LEN_BITS-1:0]       len_t;
  typedef logic [ACC_BITS-1:0]       acc_t;

  localparam addr_t MAX_ADDRESS = addr_t'((64'd1 << (ADDR_SIZE_BITS - 1)) - 64'd1);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_e;

  // A burst is legal when non-empty, access-aligned and fully inside the SRAM.
  function automatic logic cmd_legal(addr_t addr, len_t len);
    logic [CHK_BITS-1:0] end_addr;
    end_addr = CHK_BITS'(addr) + CHK_BITS'(len) * CHK_BITS'(DATA_SIZE_WORDS) - CHK_BITS'(1);
    return (len != '0) &&
           ((addr % ADDR_SIZE_BITS'(DATA_SIZE_WORDS)) == '0) &&
           (end_addr <= CHK_BITS'(MAX_ADDRESS));
  endfunction

endpackage

// File: rtl/sram_burst_master_if.sv
// Client + SRAM bus bundle for sram_burst_master.
// master: the burst master (drives cmd_ready, wr_ready, rd_valid/rd_data,
//         busy/done/err and the sram_* request signals).
// slave : the environment (clients and the SRAM wrapper).
interface sram_burst_master_if;
  import sram_master_pkg::*;

  logic  cmd_valid;
  logic  cmd_ready;
  logic  cmd_write;
  addr_t cmd_addr;
  len_t  cmd_len;
  logic  wr_valid;
  logic  wr_ready;
  acc_t  wr_data;
  logic  rd_valid;
  logic  rd_ready;
  acc_t  rd_data;
  logic  busy;
  logic  done;
  logic  err;
  logic  sram_read_enable;
  logic  sram_write_enable;
  addr_t sram_address;
  acc_t  sram_write_data;
  acc_t  sram_read_data;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           sram_read_data,
    output cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready,
           sram_read_data,
    input  cmd_ready, wr_ready, rd_valid, rd_data, busy, done, err,
           sram_read_enable, sram_write_enable, sram_address, sram_write_data
  );

endinterface

// File: rtl/sram_rd_fifo.sv
// Small synchronous FIFO buffering SRAM read responses.
// Ports: clk, rst (sync, active-high), push_i/din_i write side,
//        pop_i/dout_o read side (dout_o is the head), count_o/empty_o/full_o status.
// Push and pop together keep the occupancy; the popped entry is the old head.
module sram_rd_fifo #(
  parameter  int unsigned WIDTH    = 8,
  parameter  int unsigned DEPTH    = 2,
  localparam int unsigned CNT_BITS = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push_i,
  input  logic                pop_i,
  input  logic [WIDTH-1:0]    din_i,
  output logic [WIDTH-1:0]    dout_o,
  output logic [CNT_BITS-1:0] count_o,
  output logic                empty_o,
  output logic                full_o
);

  localparam int unsigned PTR_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [PTR_BITS-1:0] rptr_q, wptr_q;
  logic [CNT_BITS-1:0] count_q;
  logic                do_push, do_pop;

  function automatic logic [PTR_BITS-1:0] ptr_next(logic [PTR_BITS-1:0] p);
    return (p == PTR_BITS'(DEPTH - 1)) ? '0 : p + PTR_BITS'(1);
  endfunction

  // Pop only real data; a push into a full FIFO is allowed only alongside a pop.
  assign do_pop  = pop_i & (count_q != '0);
  assign do_push = push_i & ((count_q != CNT_BITS'(DEPTH)) | do_pop);

  // Storage (no reset needed; validity tracked by count_q).
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= din_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= ptr_next(wptr_q);
      if (do_pop)  rptr_q <= ptr_next(rptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CNT_BITS'(1);
        2'b01:   count_q <= count_q - CNT_BITS'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign dout_o  = mem_q[rptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_BITS'(DEPTH));

endmodule

// File: rtl/sram_burst_master.sv
// Burst initiator for the on-chip SRAM wrapper.
// Ports: clk, rst (sync, active-high); bus (sram_burst_master_if.master):
//   cmd_*  burst command handshake (cmd_ready only in IDLE with empty read buffer)
//   wr_*   write beat stream into the SRAM
//   rd_*   read beat stream out of the response FIFO
//   busy/done/err  status (done and err are one-cycle pulses)
//   sram_* registered SRAM requests; sram_read_data returns in the enable cycle.
module sram_burst_master
  import sram_master_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  sram_burst_master_if.master  bus
);

  localparam int unsigned CNT_BITS = $clog2(RD_FIFO_DEPTH + 1);
  localparam int unsigned FLT_BITS = CNT_BITS + 1;

  state_e state_q;
  addr_t  addr_q;
  len_t   rem_q;
  logic   sram_re_q, sram_we_q;
  addr_t  sram_addr_q;
  acc_t   sram_wdata_q;
  logic   done_q, err_q;

  logic                fifo_push, fifo_pop, fifo_empty, fifo_full;
  acc_t                fifo_dout;
  logic [CNT_BITS-1:0] fifo_count;
  logic [FLT_BITS-1:0] in_flight;
  logic                cmd_ready, cmd_fire, wr_ready, wr_fire, rd_issue;

  sram_rd_fifo #(
    .WIDTH (ACC_BITS),
    .DEPTH (RD_FIFO_DEPTH)
  ) u_rd_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .din_i   (bus.sram_read_data),
    .dout_o  (fifo_dout),
    .count_o (fifo_count),
    .empty_o (fifo_empty),
    .full_o  (fifo_full)
  );

  // The read issued last cycle lands in the FIFO at the end of this cycle.
  assign fifo_push = sram_re_q;
  assign fifo_pop  = bus.rd_ready & ~fifo_empty;

  // Buffered + outstanding entries, crediting a pop this cycle so a consumer
  // holding rd_ready high sees one beat per cycle.
  assign in_flight = FLT_BITS'(fifo_count) + FLT_BITS'(sram_re_q) - FLT_BITS'(fifo_pop);

  assign cmd_ready = (state_q == IDLE) & fifo_empty;
  assign cmd_fire  = bus.cmd_valid & cmd_ready;
  assign wr_ready  = (state_q == WRITE) & (rem_q != '0);
  assign wr_fire   = bus.wr_valid & wr_ready;
  assign rd_issue  = (state_q == READ) & (rem_q != '0) &
                     ~(fifo_full & ~fifo_pop) &
                     (in_flight < FLT_BITS'(RD_FIFO_DEPTH));

  // Burst sequencer with registered SRAM requests and status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      sram_re_q    <= 1'b0;
      sram_we_q    <= 1'b0;
      sram_addr_q  <= '0;
      sram_wdata_q <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      sram_re_q <= 1'b0;
      sram_we_q <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (cmd_fire) begin
            if (cmd_legal(bus.cmd_addr, bus.cmd_len)) begin
              addr_q  <= bus.cmd_addr;
              rem_q   <= bus.cmd_len;
              state_q <= bus.cmd_write ? WRITE : READ;
            end else begin
              err_q <= 1'b1;
            end
          end
        end
        WRITE: begin
          if (wr_fire) begin
            sram_we_q    <= 1'b1;
            sram_addr_q  <= addr_q;
            sram_wdata_q <= bus.wr_data;
            addr_q       <= addr_q + ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
            rem_q        <= rem_q - LEN_BITS'(1);
            if (rem_q == LEN_BITS'(1)) state_q <= DRAIN;
          end
        end
        READ: begin
          if (rd_issue) begin
            sram_re_q   <= 1'b1;
            sram_addr_q <= addr_q;
            addr_q      <= addr_q + ADDR_SIZE_BITS'(DATA_SIZE_WORDS);
            rem_q       <= rem_q - LEN_BITS'(1);
            if (rem_q == LEN_BITS'(1)) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          // Final access is on the SRAM this cycle; completion follows it.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready         = cmd_ready;
  assign bus.wr_ready          = wr_ready;
  assign bus.rd_valid          = ~fifo_empty;
  assign bus.rd_data           = fifo_dout;
  assign bus.busy              = (state_q != IDLE);
  assign bus.done              = done_q;
  assign bus.err               = err_q;
  assign bus.sram_read_enable  = sram_re_q;
  assign bus.sram_write_enable = sram_we_q;
  assign bus.sram_address      = sram_addr_q;
  assign bus.sram_write_data   = sram_wdata_q;

endmodule

// File: doc/sram_burst_master.md
Name: sram_burst_master

Overview:
Initiator for the on-chip SRAM wrapper interface (read_enable / write_enable / address / write_data / read_data).
- Accepts burst commands from GPU-side clients (rasterizer, framebuffer scan-out) over valid/ready.
- Streams write data into the SRAM, or streams read data back with backpressure.
- Guarantees the SRAM never sees read_enable and write_enable together, and never sees an out-of-range access.

Parameters:
- ADDR_SIZE_BITS, 22: SRAM address width; capacity is 2^(ADDR_SIZE_BITS-1) words, so MAX_ADDRESS = 0x1FFFFF.
- DATA_SIZE_WORDS, 2: words per SRAM access; the address advances by this amount per beat.
- WORD_SIZE_BYTES, 3: bytes per word; ACC_BITS = DATA_SIZE_WORDS*WORD_SIZE_BYTES*8 = 48.
- LEN_BITS, 8: burst length field width, in accesses.
- RD_FIFO_DEPTH, 2: read response buffer depth.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  high only in IDLE.
- cmd_write  in  1  1 = write burst, 0 = read burst.
- cmd_addr  in  ADDR_SIZE_BITS  first word address.
- cmd_len  in  LEN_BITS  number of accesses (1..255).
- wr_valid  in  1  write beat offered.
- wr_ready  out  1  write beat accepted.
- wr_data  in  ACC_BITS  write beat data.
- rd_valid  out  1  read beat available (FIFO not empty).
- rd_ready  in  1  consumer accepts the read beat.
- rd_data  out  ACC_BITS  read beat data (FIFO head).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse at burst completion.
- err  out  1  one-cycle pulse on command rejection.
- sram_read_enable  out  1  registered.
- sram_write_enable  out  1  registered.
- sram_address  out  ADDR_SIZE_BITS  registered.
- sram_write_data  out  ACC_BITS  registered.
- sram_read_data  in  ACC_BITS  valid by the end of the cycle in which sram_read_enable is high.

Behaviour:
- Reset: after an edge with rst=1:
  - State returns to IDLE and the FIFO is flushed.
  - All SRAM outputs, rd_valid, wr_ready, done, err and busy are 0; cmd_ready is 1.
  - Applies mid-burst; a partial burst is abandoned with no done.
- Command check on cmd_valid & cmd_ready. Reject if any of:
  - cmd_len == 0;
  - cmd_addr is not a multiple of DATA_SIZE_WORDS;
  - end = cmd_addr + cmd_len*DATA_SIZE_WORDS - 1 > MAX_ADDRESS, computed at ADDR_SIZE_BITS+LEN_BITS+1 width.
- On reject: err pulses the next cycle, state stays IDLE, no SRAM access is made.
- IDLE -> WRITE or READ on an accepted command. The address and remaining-count registers load from the command.
- WRITE:
  - wr_ready = (remaining != 0).
  - On each wr_valid & wr_ready: next cycle sram_write_enable=1, sram_address=current, sram_write_data=wr_data. Then the address increments by DATA_SIZE_WORDS and remaining decrements.
  - Gaps in wr_valid produce idle SRAM cycles (both enables 0).
  - When the last beat is accepted, go to DRAIN.
- READ:
  - Issue when remaining != 0 and (fifo_count + outstanding) < RD_FIFO_DEPTH. outstanding is 0 or 1 (the registered enable stage).
  - An issue sets sram_read_enable=1 and sram_address next cycle.
  - sram_read_data is pushed into the FIFO at the end of each cycle with sram_read_enable=1.
  - After the last issue, go to DRAIN.
  - Sustains one beat per cycle when rd_ready is held high.
- DRAIN:
  - Waits one cycle for the final registered access.
  - Pulses done in the cycle after the last sram_*_enable=1 cycle, then returns to IDLE.
  - Already-buffered read data may remain in the FIFO after done; rd_valid stays high until it is consumed.
- A new command is not accepted while the FIFO is non-empty from a previous read. cmd_ready = IDLE & fifo_empty.
- Invariants:
  - sram_read_enable & sram_write_enable is never 1.
  - sram_address is never > MAX_ADDRESS while an enable is high.
  - sram_write_data holds its last value when idle.
- FIFO push and pop in the same cycle: occupancy is unchanged, and the popped entry is the old head.

Decomposition:
- Package sram_master_pkg holds:
  - ADDR_SIZE_BITS, DATA_SIZE_WORDS, WORD_SIZE_BYTES, ACC_BITS, MAX_ADDRESS;
  - the state enum {IDLE, WRITE, READ, DRAIN}.
- One sub-module, sram_rd_fifo: a parameterized synchronous FIFO with inputs push/pop/din, outputs dout/count/empty/full, and clk/rst.

Test Plan:
1. Write cmd addr 0, len 1, wr_data 0xFFFFFFFFFFFF -> exactly one cycle with sram_write_enable=1, address 0, data all ones; done pulses the next cycle; cmd_ready returns to 1.
2. Write addr 8, len 4, data 5, 6, 7, 8, with wr_valid dropped for 2 cycles between beats 2 and 3 -> write enables at addresses 8, 10, 12, 14 only; idle cycles in the gap; one done pulse.
3. Read addr 8, len 4 against an SRAM model holding test 2's data, rd_ready low for 5 cycles then high -> at most 2 read enables before stalling; rd_data order 5, 6, 7, 8; no beat lost or duplicated.
4. Rejects -> err pulse and zero SRAM activity for each of: len=0; addr=1, len=1; addr 0x1FFFFE, len=2.
5. Accepted boundary: addr 0x1FFFFE, len=1 -> accepted, one access at 0x1FFFFE.
6. Assert rst during the 3rd beat of a read burst of len 10 -> after the edge: enables 0, rd_valid 0, busy 0, cmd_ready 1, no done.
7. Back-to-back read len 3 then write len 3 (issued as soon as cmd_ready) -> both enables never high together; write starts only after the FIFO has drained.
